// File: rtl/err_stat_monitor_if.sv
// Bus bundle for err_stat_monitor: run control, sample handshake and
// the statistic outputs. The monitor uses the slave side.
interface err_stat_monitor_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic                                     start;
  logic [CNT_WIDTH-1:0]                     num_samples;
  logic                                     in_valid;
  logic                                     in_ready;
  logic signed [DATA_WIDTH-1:0]             appr;
  logic signed [DATA_WIDTH-1:0]             precise;
  logic                                     busy;
  logic                                     done;
  logic [CNT_WIDTH-1:0]                     sample_cnt;
  logic [CNT_WIDTH-1:0]                     same_cnt;
  logic signed [DATA_WIDTH+CNT_WIDTH:0]     err_sum;
  logic [DATA_WIDTH+CNT_WIDTH:0]            abs_err_sum;
  logic [2*(DATA_WIDTH+1)+CNT_WIDTH-1:0]    sq_err_sum;
  logic [DATA_WIDTH+CNT_WIDTH-1:0]          abs_result_sum;
  logic [DATA_WIDTH:0]                      max_abs_err;

  modport master (
    output start, num_samples, in_valid, appr, precise,
    input  in_ready, busy, done, sample_cnt, same_cnt, err_sum,
           abs_err_sum, sq_err_sum, abs_result_sum, max_abs_err
  );

  modport slave (
    input  start, num_samples, in_valid, appr, precise,
    output in_ready, busy, done, sample_cnt, same_cnt, err_sum,
           abs_err_sum, sq_err_sum, abs_result_sum, max_abs_err
  );
endinterface

// File: rtl/err_stat_monitor.sv
// Error statistics monitor: accepts N (approximate, exact) result pairs,
// computes the error in a first pipeline stage and accumulates signed,
// absolute and squared error sums, |exact| sum and max |error| in a second.
module err_stat_monitor #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input logic               clk,
  input logic               rst,
  err_stat_monitor_if.slave bus
);
  localparam int unsigned EW = DATA_WIDTH + 1;           // error width
  localparam int unsigned SW = EW + CNT_WIDTH;           // error sum width
  localparam int unsigned QW = 2 * EW + CNT_WIDTH;       // squared sum width
  localparam int unsigned RW = DATA_WIDTH + CNT_WIDTH;   // |precise| sum width
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                   state_q, state_d;
  logic [CNT_WIDTH-1:0]     n_q, n_d;
  logic [CNT_WIDTH-1:0]     acc_q, acc_d;

  logic                     s1_valid_q, s1_valid_d;
  logic signed [EW-1:0]     s1_err_q, s1_err_d;
  logic [EW-1:0]            s1_abs_err_q, s1_abs_err_d;
  logic [DATA_WIDTH-1:0]    s1_abs_prec_q, s1_abs_prec_d;

  logic [CNT_WIDTH-1:0]     sample_cnt_q, sample_cnt_d;
  logic [CNT_WIDTH-1:0]     same_cnt_q, same_cnt_d;
  logic signed [SW-1:0]     err_sum_q, err_sum_d;
  logic [SW-1:0]            abs_err_sum_q, abs_err_sum_d;
  logic [QW-1:0]            sq_err_sum_q, sq_err_sum_d;
  logic [RW-1:0]            abs_result_sum_q, abs_result_sum_d;
  logic [EW-1:0]            max_abs_err_q, max_abs_err_d;

  logic signed [EW-1:0]     err_w;
  logic [EW-1:0]            abs_err_w;
  logic [DATA_WIDTH-1:0]    abs_prec_w;
  logic [2*EW-1:0]          sq_w;
  logic                     in_ready_w;
  logic                     accept_w;

  // Stage-1 arithmetic on the incoming pair and the square of the staged error
  always_comb begin
    err_w      = {bus.appr[DATA_WIDTH-1], bus.appr} - {bus.precise[DATA_WIDTH-1], bus.precise};
    abs_err_w  = err_w[EW-1] ? -err_w : err_w;
    // negating the most negative value yields 100..0, which is the correct unsigned magnitude
    abs_prec_w = bus.precise[DATA_WIDTH-1] ? -bus.precise : bus.precise;
    sq_w       = {{EW{1'b0}}, s1_abs_err_q} * {{EW{1'b0}}, s1_abs_err_q};
  end

  // Next-state: run control, stage-1 capture and stage-2 accumulation
  always_comb begin
    state_d          = state_q;
    n_d              = n_q;
    acc_d            = acc_q;
    s1_valid_d       = 1'b0;
    s1_err_d         = s1_err_q;
    s1_abs_err_d     = s1_abs_err_q;
    s1_abs_prec_d    = s1_abs_prec_q;
    sample_cnt_d     = sample_cnt_q;
    same_cnt_d       = same_cnt_q;
    err_sum_d        = err_sum_q;
    abs_err_sum_d    = abs_err_sum_q;
    sq_err_sum_d     = sq_err_sum_q;
    abs_result_sum_d = abs_result_sum_q;
    max_abs_err_d    = max_abs_err_q;

    in_ready_w = (state_q == RUN) && (acc_q < n_q);
    accept_w   = bus.in_valid && in_ready_w;

    if (bus.start) begin
      // start wins over any accept or retire on the same edge
      n_d              = bus.num_samples;
      acc_d            = '0;
      sample_cnt_d     = '0;
      same_cnt_d       = '0;
      err_sum_d        = '0;
      abs_err_sum_d    = '0;
      sq_err_sum_d     = '0;
      abs_result_sum_d = '0;
      max_abs_err_d    = '0;
      state_d          = (bus.num_samples == '0) ? DONE : RUN;
    end else begin
      if (s1_valid_q) begin
        err_sum_d        = err_sum_q + {{CNT_WIDTH{s1_err_q[EW-1]}}, s1_err_q};
        abs_err_sum_d    = abs_err_sum_q + {{CNT_WIDTH{1'b0}}, s1_abs_err_q};
        sq_err_sum_d     = sq_err_sum_q + {{CNT_WIDTH{1'b0}}, sq_w};
        abs_result_sum_d = abs_result_sum_q + {{CNT_WIDTH{1'b0}}, s1_abs_prec_q};
        sample_cnt_d     = sample_cnt_q + CNT_ONE;
        if (s1_err_q == '0) begin
          same_cnt_d = same_cnt_q + CNT_ONE;
        end
        if (s1_abs_err_q > max_abs_err_q) begin
          max_abs_err_d = s1_abs_err_q;
        end
        if (sample_cnt_d == n_q) begin
          state_d = DONE;
        end
      end
      if (accept_w) begin
        s1_valid_d    = 1'b1;
        s1_err_d      = err_w;
        s1_abs_err_d  = abs_err_w;
        s1_abs_prec_d = abs_prec_w;
        acc_d         = acc_q + CNT_ONE;
      end
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      n_q              <= '0;
      acc_q            <= '0;
      s1_valid_q       <= 1'b0;
      s1_err_q         <= '0;
      s1_abs_err_q     <= '0;
      s1_abs_prec_q    <= '0;
      sample_cnt_q     <= '0;
      same_cnt_q       <= '0;
      err_sum_q        <= '0;
      abs_err_sum_q    <= '0;
      sq_err_sum_q     <= '0;
      abs_result_sum_q <= '0;
      max_abs_err_q    <= '0;
    end else begin
      state_q          <= state_d;
      n_q              <= n_d;
      acc_q            <= acc_d;
      s1_valid_q       <= s1_valid_d;
      s1_err_q         <= s1_err_d;
      s1_abs_err_q     <= s1_abs_err_d;
      s1_abs_prec_q    <= s1_abs_prec_d;
      sample_cnt_q     <= sample_cnt_d;
      same_cnt_q       <= same_cnt_d;
      err_sum_q        <= err_sum_d;
      abs_err_sum_q    <= abs_err_sum_d;
      sq_err_sum_q     <= sq_err_sum_d;
      abs_result_sum_q <= abs_result_sum_d;
      max_abs_err_q    <= max_abs_err_d;
    end
  end

  assign bus.in_ready       = in_ready_w;
  assign bus.busy           = (state_q == RUN);
  assign bus.done           = (state_q == DONE);
  assign bus.sample_cnt     = sample_cnt_q;
  assign bus.same_cnt       = same_cnt_q;
  assign bus.err_sum        = err_sum_q;
  assign bus.abs_err_sum    = abs_err_sum_q;
  assign bus.sq_err_sum     = sq_err_sum_q;
  assign bus.abs_result_sum = abs_result_sum_q;
  assign bus.max_abs_err    = max_abs_err_q;
endmodule

// File: tb/tb_err_stat_monitor.sv
// Bench for err_stat_monitor: every cycle is checked against a
// sample-list reference model; directed runs also check fixed totals.
module tb_err_stat_monitor;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  err_stat_monitor_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  err_stat_monitor #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  // reference model: run mode, target, accepted count, one-deep in-flight list
  int          m_mode;   // 0 idle, 1 running, 2 finished
  int          m_n, m_acc, m_cnt, m_same;
  longint      m_err, m_abs, m_res, m_max;
  logic [81:0] m_sq;
  longint      pend_err[$];
  longint      pend_res[$];

  typedef struct {
    logic signed [31:0] appr;
    logic signed [31:0] prec;
    longint             e_err;
    longint             e_abs;
    logic [81:0]        e_sq;
    longint             e_res;
    longint             e_max;
    int                 e_same;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_cnt = 0; m_same = 0; m_err = 0; m_abs = 0; m_res = 0; m_max = 0; m_sq = '0;
    m_acc = 0;
    pend_err.delete();
    pend_res.delete();
  endtask

  task automatic check_all();
    chk("in_ready",       128'(bus.in_ready), 128'(m_mode == 1 && m_acc < m_n));
    chk("busy",           128'(bus.busy), 128'(m_mode == 1));
    chk("done",           128'(bus.done), 128'(m_mode == 2));
    chk("sample_cnt",     128'(bus.sample_cnt), 128'(m_cnt));
    chk("same_cnt",       128'(bus.same_cnt), 128'(m_same));
    chk("err_sum",        128'($signed(bus.err_sum)), 128'(m_err));
    chk("abs_err_sum",    128'(bus.abs_err_sum), 128'(m_abs));
    chk("sq_err_sum",     128'(bus.sq_err_sum), 128'(m_sq));
    chk("abs_result_sum", 128'(bus.abs_result_sum), 128'(m_res));
    chk("max_abs_err",    128'(bus.max_abs_err), 128'(m_max));
  endtask

  // advance one clock, update the model with what that edge should do, compare
  task automatic tick();
    bit     rdy;
    longint e, ae, p;
    rdy = (m_mode == 1) && (m_acc < m_n);
    @(posedge clk);
    if (rst) begin
      model_clear(); m_mode = 0; m_n = 0;
    end else if (bus.start) begin
      model_clear();
      m_n = int'(bus.num_samples);
      m_mode = (m_n == 0) ? 2 : 1;
    end else begin
      if (pend_err.size() > 0) begin
        e = pend_err.pop_front();
        p = pend_res.pop_front();
        ae = (e < 0) ? -e : e;
        m_err += e; m_abs += ae; m_res += p;
        m_sq = m_sq + 82'(ae) * 82'(ae);
        if (e == 0) m_same++;
        if (ae > m_max) m_max = ae;
        m_cnt++;
        if (m_cnt == m_n) m_mode = 2;
      end
      if (bus.in_valid && rdy) begin
        e = longint'(bus.appr) - longint'(bus.precise);
        p = longint'(bus.precise);
        pend_err.push_back(e);
        pend_res.push_back((p < 0) ? -p : p);
        m_acc++;
      end
    end
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0; bus.in_valid = 1'b0;
  endtask

  task automatic do_start(input int n);
    bus.start = 1'b1; bus.num_samples = CW'(n); bus.in_valid = 1'b0;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send(input logic signed [31:0] a, input logic signed [31:0] p);
    bus.in_valid = 1'b1; bus.appr = a; bus.precise = p;
    tick();
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    bus.in_valid = 1'b0;
    while (!bus.done && c < budget) begin
      tick();
      c++;
    end
    if (!bus.done) chk("wait_done_timeout", 128'(0), 128'(1));
  endtask

  task automatic chk_final(input string tag, input longint e_err, input longint e_abs,
                           input logic [81:0] e_sq, input longint e_res, input longint e_max,
                           input int e_same);
    chk({tag, "_done"},    128'(bus.done), 128'(1));
    chk({tag, "_err"},     128'($signed(bus.err_sum)), 128'(e_err));
    chk({tag, "_abs"},     128'(bus.abs_err_sum), 128'(e_abs));
    chk({tag, "_sq"},      128'(bus.sq_err_sum), 128'(e_sq));
    chk({tag, "_res"},     128'(bus.abs_result_sum), 128'(e_res));
    chk({tag, "_max"},     128'(bus.max_abs_err), 128'(e_max));
    chk({tag, "_same"},    128'(bus.same_cnt), 128'(e_same));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'sh7FFFFFFF, 32'sh80000000, 64'sd4294967295, 64'sd4294967295,
                82'hFFFF_FFFE_0000_0001, 64'sd2147483648, 64'sd4294967295, 0};
    vecs[1] = '{32'sh80000000, 32'sh7FFFFFFF, -64'sd4294967295, 64'sd4294967295,
                82'hFFFF_FFFE_0000_0001, 64'sd2147483647, 64'sd4294967295, 0};
    vecs[2] = '{32'sd0, 32'sd0, 64'sd0, 64'sd0, 82'd0, 64'sd0, 64'sd0, 1};
    vecs[3] = '{-32'sd3, 32'sd4, -64'sd7, 64'sd7, 82'd49, 64'sd4, 64'sd7, 0};
    vecs[4] = '{32'sh80000000, 32'sh80000000, 64'sd0, 64'sd0, 82'd0, 64'sd2147483648, 64'sd0, 1};

    m_mode = 0; m_n = 0; model_clear();
    idle_inputs(); bus.num_samples = '0; bus.appr = '0; bus.precise = '0;

    // reset state
    rst = 1'b1; tick(); tick();
    rst = 1'b0; tick();

    // single-sample table, including the most negative/positive extremes
    for (int unsigned i = 0; i < 5; i++) begin
      do_start(1);
      send(vecs[i].appr, vecs[i].prec);
      wait_done(4);
      chk_final("vec", vecs[i].e_err, vecs[i].e_abs, vecs[i].e_sq,
                vecs[i].e_res, vecs[i].e_max, vecs[i].e_same);
    end

    // all-exact run, back to back
    do_start(4);
    send(100, 100); send(-7, -7); send(0, 0); send(5, 5);
    wait_done(4);
    chk_final("exact4", 0, 0, 82'd0, 112, 0, 4);

    // mixed errors
    do_start(3);
    send(10, 7); send(-5, -1); send(0, 2);
    wait_done(4);
    chk_final("mix3", -3, 9, 82'd29, 10, 4, 0);

    // gaps, then a 4th valid held after the 3rd accept
    do_start(3);
    send(1, 2); idle_inputs(); tick();
    send(3, 3); idle_inputs(); tick(); tick();
    send(-4, 0);
    chk("gap_ready_low", 128'(bus.in_ready), 128'(0));
    send(9, 1);
    chk("gap_done_next", 128'(bus.done), 128'(1));
    send(9, 1); send(9, 1);
    chk("gap_cnt", 128'(bus.sample_cnt), 128'(3));
    chk_final("gap3", -5, 5, 82'd17, 5, 4, 1);
    idle_inputs();

    // zero-length run
    do_start(0);
    chk("n0_done", 128'(bus.done), 128'(1));
    chk("n0_ready", 128'(bus.in_ready), 128'(0));
    tick();

    // reset mid-run overrides start and valid, then a clean run
    do_start(5);
    send(50, 1); send(-20, 3);
    rst = 1'b1; bus.start = 1'b1; bus.num_samples = CW'(3); bus.in_valid = 1'b1;
    tick();
    rst = 1'b0; idle_inputs();
    chk("rst_busy", 128'(bus.busy), 128'(0));
    chk("rst_err",  128'(bus.abs_err_sum), 128'(0));
    tick();
    do_start(2);
    send(6, 2); send(1, 3);
    wait_done(4);
    chk_final("after_rst", 2, 6, 82'd20, 5, 4, 0);

    // start coincident with an accept discards the in-flight sample
    do_start(3);
    send(40, 0);
    bus.start = 1'b1; bus.num_samples = CW'(1); bus.in_valid = 1'b1;
    bus.appr = 77; bus.precise = 0;
    tick();
    bus.start = 1'b0;
    send(2, 5);
    wait_done(4);
    chk_final("prio", -3, 3, 82'd9, 5, 3, 0);

    // randomized runs against the model
    for (int unsigned r = 0; r < 40; r++) begin
      int n = $urandom_range(0, 7);
      do_start(n);
      for (int unsigned c = 0; c < 30; c++) begin
        int sel = $urandom_range(0, 3);
        bus.in_valid = ($urandom_range(0, 9) < 7);
        bus.appr     = (sel == 0) ? 32'sh80000000 : $urandom;
        bus.precise  = (sel == 1) ? 32'sh7FFFFFFF : ((sel == 2) ? bus.appr : $urandom);
        if ($urandom_range(0, 59) == 0) begin
          bus.start = 1'b1; bus.num_samples = CW'($urandom_range(0, 7));
        end
        if ($urandom_range(0, 79) == 0) rst = 1'b1;
        tick();
        bus.start = 1'b0; rst = 1'b0;
      end
      idle_inputs();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/err_stat_monitor.md
ERR_STAT_MONITOR -- requirements
Module: err_stat_monitor

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of the signed result operands (shifted multiplier output and golden product).
REQ-002 Parameter CNT_WIDTH, default 16, width of the sample counters.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; clears the statistics and arms a run.
REQ-006 num_samples  input  CNT_WIDTH  unsigned sample count N, sampled when start is accepted.
REQ-007 in_valid  input  1  sample pair present.
REQ-008 in_ready  output  1  monitor accepts a sample this cycle.
REQ-009 appr  input  DATA_WIDTH  signed approximate result.
REQ-010 precise  input  DATA_WIDTH  signed exact result.
REQ-011 busy / done  output  1 each  run in progress / statistics final.
REQ-012 sample_cnt, same_cnt  output  CNT_WIDTH each  retired samples / samples with zero error.
REQ-013 err_sum  output  DATA_WIDTH+1+CNT_WIDTH  signed sum of errors.
REQ-014 abs_err_sum  output  DATA_WIDTH+1+CNT_WIDTH  unsigned sum of |error|.
REQ-015 sq_err_sum  output  2*(DATA_WIDTH+1)+CNT_WIDTH  unsigned sum of error squared.
REQ-016 abs_result_sum  output  DATA_WIDTH+CNT_WIDTH  unsigned sum of |precise|.
REQ-017 max_abs_err  output  DATA_WIDTH+1  unsigned maximum |error|.

Function
REQ-018 The FSM SHALL have states IDLE, RUN, DONE; busy=1 only in RUN, done=1 only in DONE.
REQ-019 start in any state SHALL clear all statistic outputs, latch num_samples, and go to RUN (or DONE if num_samples=0) at the next edge.
REQ-020 in_ready SHALL be 1 only in RUN while accepted-count < N, and SHALL be combinational from state and counter only (not from in_valid).
REQ-021 A sample SHALL be accepted on an edge where in_valid=1 and in_ready=1; in_valid while in_ready=0 SHALL be ignored.
REQ-022 Stage 1 (accept edge): error = appr - precise, computed sign-extended to DATA_WIDTH+1 bits, plus |error| and |precise| (|-2^(DATA_WIDTH-1)| = 2^(DATA_WIDTH-1)), registered.
REQ-023 Stage 2 (next edge): all sums, sample_cnt, same_cnt (if error=0) and max_abs_err SHALL update; a sample's contribution is visible one cycle after its accept edge.
REQ-024 Back-to-back accepts SHALL be sustained at one per cycle with no bubbles.
REQ-025 Accumulators SHALL never wrap; widths are sized for N up to 2^CNT_WIDTH-1 at worst-case magnitudes.
REQ-026 RUN->DONE SHALL occur on the same edge that retires sample N; done and final statistics become visible together.
REQ-027 DONE SHALL hold all outputs stable until start or rst.
REQ-028 start coincident with an accept SHALL take priority: the in-flight sample is discarded and the new run begins from zero.

Reset
REQ-029 rst SHALL force IDLE and set in_ready, busy, done and every statistic output to 0, discard pipeline contents, and override start and in_valid in the same cycle.
REQ-030 rst asserted mid-run SHALL abandon the run; a subsequent start SHALL behave as from power-up.

Verification
REQ-031 N=4, pairs (100,100),(-7,-7),(0,0),(5,5) -> same_cnt=4, err_sum=0, abs_err_sum=0, sq_err_sum=0, abs_result_sum=112, max_abs_err=0, done=1.
REQ-032 N=3, (appr,precise) = (10,7),(-5,-1),(0,2) -> err_sum=-3, abs_err_sum=9, sq_err_sum=29, max_abs_err=4, same_cnt=0, abs_result_sum=10.
REQ-033 N=3 with in_valid gaps and a 4th valid held after the 3rd accept -> in_ready=0 after the 3rd accept, sample_cnt=3, the 4th sample is not counted, done one cycle after the 3rd accept.
REQ-034 start with num_samples=0 -> done=1 and in_ready=0 after the next edge, all statistics 0.
REQ-035 N=1, appr=0x7FFFFFFF, precise=0x80000000 -> err_sum=4294967295, sq_err_sum=18446744065119617025, max_abs_err=4294967295, abs_result_sum=2147483648.
REQ-036 N=5: rst for one cycle after 2 accepts -> all outputs 0, IDLE; then start with N=2 and 2 samples -> correct stats with no residue from the first run.
